// File: rtl/comparenb_seq.sv
// rtl/comparenb_seq.sv - bit-serial MSB-first signed/unsigned magnitude comparator
module comparenb_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             y
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             sh_sgn;
  logic [5:0]       cnt;
  logic             decided;
  logic             dec_lt;
  logic             dec_gt;

  logic             nxt_decided;
  logic             nxt_lt;
  logic             nxt_gt;
  logic             msb_a;
  logic             msb_b;
  logic             first_bit;

  // The first examined bit is the sign bit; in signed mode a 1 there means smaller.
  always_comb begin
    msb_a       = sh_a[WIDTH-1];
    msb_b       = sh_b[WIDTH-1];
    first_bit   = (cnt == 6'(WIDTH));
    nxt_decided = decided;
    nxt_lt      = dec_lt;
    nxt_gt      = dec_gt;
    if (!decided && (msb_a != msb_b)) begin
      nxt_decided = 1'b1;
      if (sh_sgn && first_bit) begin
        nxt_lt = msb_a;
        nxt_gt = msb_b;
      end else begin
        nxt_lt = msb_b;
        nxt_gt = msb_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      sh_sgn  <= 1'b0;
      cnt     <= '0;
      decided <= 1'b0;
      dec_lt  <= 1'b0;
      dec_gt  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      y       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a    <= a;
            sh_b    <= b;
            sh_sgn  <= sgn;
            cnt     <= 6'(WIDTH);
            decided <= 1'b0;
            dec_lt  <= 1'b0;
            dec_gt  <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sh_a    <= sh_a << 1;
          sh_b    <= sh_b << 1;
          cnt     <= cnt - 6'd1;
          decided <= nxt_decided;
          dec_lt  <= nxt_lt;
          dec_gt  <= nxt_gt;
          if (cnt == 6'd1) begin
            lt    <= nxt_lt;
            gt    <= nxt_gt;
            eq    <= ~nxt_decided;
            y     <= nxt_lt | ~nxt_decided;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparenb_seq.sv
// tb/tb_comparenb_seq.sv - randomized bench for comparenb_seq against an arithmetic reference
module tb_comparenb_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sgn = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, lt, eq, gt, y;

  logic       rst1 = 1'b1;
  logic       start1 = 1'b0;
  logic       sgn1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, lt1, eq1, gt1, y1;

  int errors = 0;
  int checks = 0;

  logic       m_busy = 0, m_done = 0, m_lt = 0, m_eq = 0, m_gt = 0, m_y = 0;
  logic [2:0] m_pend = '0;
  int         m_left = 0;
  int         done_count = 0;
  logic       prev_done = 0;

  comparenb_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt), .y(y)
  );

  comparenb_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .sgn(sgn1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .y(y1)
  );

  always #5 clk = ~clk;

  // Returns {lt, eq, gt} from the numeric values of the operands.
  function automatic logic [2:0] ref_cmp(input int w, input logic s, input logic [31:0] x,
                                         input logic [31:0] z);
    longint vx, vz;
    vx = longint'(x);
    vz = longint'(z);
    if (s && x[w-1]) vx = vx - (longint'(1) << w);
    if (s && z[w-1]) vz = vz - (longint'(1) << w);
    return {vx < vz, vx == vz, vx > vz};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic s, input logic [7:0] ai,
                      input logic [7:0] bi);
    rst = r; start = st; sgn = s; a = ai; b = bi;
    @(posedge clk);
    #1;
    if (r) begin
      {m_busy, m_done, m_lt, m_eq, m_gt, m_y} = '0;
      m_left = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (st) begin
          m_pend = ref_cmp(8, s, {24'd0, ai}, {24'd0, bi});
          m_left = 8;
          m_busy = 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          {m_lt, m_eq, m_gt} = m_pend;
          m_y = m_pend[2] | m_pend[1];
        end
      end
    end
    chk("cycle", {26'd0, busy, done, lt, eq, gt, y}, {26'd0, m_busy, m_done, m_lt, m_eq, m_gt, m_y});
    chk("no_back_to_back_done", {31'd0, prev_done & done}, 32'd0);
    prev_done = done;
    if (done) done_count++;
  endtask

  // Full run; operands and sgn are scrambled while busy to show they are not re-sampled.
  task automatic run8(input logic s, input logic [7:0] ai, input logic [7:0] bi);
    step(0, 1, s, ai, bi);
    repeat (8) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), 8'($urandom));
  endtask

  task automatic run1(input logic s, input logic ai, input logic bi, output logic [5:0] res);
    start1 = 1; sgn1 = s; a1 = ai; b1 = bi;
    @(posedge clk); #1;
    chk("w1_busy", {31'd0, busy1}, 32'd1);
    start1 = 0; sgn1 = ~s; a1 = ~ai; b1 = ~bi;
    @(posedge clk); #1;
    res = {busy1, done1, lt1, eq1, gt1, y1};
  endtask

  initial begin
    logic [5:0] r1;
    logic [2:0] e1;

    step(1, 1, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00);
    chk("reset_outputs", {26'd0, busy, done, lt, eq, gt, y}, 32'd0);

    run8(0, 8'h80, 8'h7F);
    chk("u80_vs_7f", {27'd0, done, gt, lt, eq, y}, 32'b11000);
    run8(1, 8'h80, 8'h7F);
    chk("s80_vs_7f", {28'd0, lt, eq, gt, y}, 32'b1001);
    run8(1, 8'hFE, 8'hFF);
    chk("sFE_vs_FF", {28'd0, lt, eq, gt, y}, 32'b1001);
    run8(0, 8'hA5, 8'hA5);
    chk("uA5_eq", {28'd0, lt, eq, gt, y}, 32'b0101);
    run8(1, 8'hA5, 8'hA5);
    chk("sA5_eq", {28'd0, lt, eq, gt, y}, 32'b0101);

    done_count = 0;
    for (int i = 0; i < 20; i++) begin
      if (!m_busy) step(0, 1, 0, 8'd3, 8'd5);
      else step(0, 1, $urandom_range(0, 1), 8'($urandom), 8'($urandom));
    end
    chk("held_start_pulses", done_count, 32'd2);
    chk("held_start_lt", {28'd0, lt, eq, gt, y}, 32'b1001);
    repeat (8) step(0, 0, 0, 8'd0, 8'd0);

    run8(0, 8'd9, 8'd2);
    chk("pre_abort_gt", {31'd0, gt}, 32'd1);
    step(0, 1, 0, 8'd1, 8'd9);
    repeat (3) step(0, 0, 0, 8'd0, 8'd0);
    step(1, 1, 0, 8'd0, 8'd0);
    chk("abort_state", {26'd0, busy, done, lt, eq, gt, y}, 32'd0);
    repeat (9) begin
      step(0, 0, 0, 8'd0, 8'd0);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    run8(0, 8'd1, 8'd1);
    chk("after_abort_eq", {27'd0, done, lt, eq, gt, y}, 32'b10101);

    for (int k = 0; k < 300; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra ^ (8'd1 << $urandom_range(0, 7));
      step(($urandom_range(0, 63) == 0), 1, $urandom_range(0, 1), ra, rb);
      repeat ($urandom_range(0, 10))
        step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
             8'($urandom), 8'($urandom));
    end

    rst1 = 1;
    @(posedge clk); #1;
    chk("w1_reset", {26'd0, busy1, done1, lt1, eq1, gt1, y1}, 32'd0);
    rst1 = 0;
    run1(0, 1'b0, 1'b1, r1);
    chk("w1_u0_lt_1", {26'd0, r1}, 32'b011001);
    run1(1, 1'b0, 1'b1, r1);
    chk("w1_s0_gt_m1", {26'd0, r1}, 32'b010010);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 2; x++)
        for (int z = 0; z < 2; z++) begin
          run1(s[0], x[0], z[0], r1);
          e1 = ref_cmp(1, s[0], {31'd0, x[0]}, {31'd0, z[0]});
          chk("w1_sweep", {26'd0, r1}, {26'd0, 2'b01, e1, e1[2] | e1[1]});
        end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comparenb_seq.md
COMPARENB_SEQ -- requirements
Module: comparenb_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; the block SHALL use one clock, with reset synchronous and active-high.
REQ-004 Port: start  input  1  request a comparison; sampled only while busy=0.
REQ-005 Port: sgn  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
REQ-006 Port: a  input  WIDTH  operand A; captured with start.
REQ-007 Port: b  input  WIDTH  operand B; captured with start.
REQ-008 Port: busy  output  1  high while a comparison is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; results valid and updated.
REQ-010 Port: lt  output  1  A < B.
REQ-011 Port: eq  output  1  A == B.
REQ-012 Port: gt  output  1  A > B.
REQ-013 Port: y  output  1  A <= B (lt | eq).

Function
REQ-014 States SHALL be IDLE and RUN; busy SHALL be 1 exactly when state = RUN.
REQ-015 IDLE with start=1 SHALL, on the edge: capture a, b and sgn into internal shift registers, load bit counter = WIDTH, clear decision flags, and go to RUN.
REQ-016 IDLE with start=0 SHALL hold all registers unchanged.
REQ-017 Each RUN edge SHALL examine the current MSB pair of the shift registers, MSB-first, one bit per cycle, then shift both registers left by one and decrement the counter.
REQ-018 First differing bit pair decides the result; later bits SHALL NOT alter it.
REQ-019 Unsigned decision at a differing bit: the operand with bit 1 is greater.
REQ-020 Signed decision at bit WIDTH-1 (the first examined): the operand with bit 1 is smaller. At all other bits the unsigned rule applies.
REQ-021 No differing bit over all WIDTH bits SHALL yield eq=1.
REQ-022 On the RUN edge where the counter goes 1 -> 0, the block SHALL:
- write lt/eq/gt (exactly one high) and y;
- set done=1 for exactly one cycle;
- return to IDLE.
REQ-023 Latency: if start is sampled at edge E0, done SHALL be high in the cycle following edge E0+WIDTH, so busy is high for exactly WIDTH cycles.
REQ-024 lt/eq/gt/y SHALL hold their last values until the next done; starting a new comparison SHALL NOT clear them.
REQ-025 start while busy=1 SHALL be ignored, with no effect on the comparison in progress and no queuing.
REQ-026 start during the done cycle (state IDLE) SHALL be accepted; done SHALL then be 0 in the following cycle and busy 1.
REQ-027 Operand or sgn changes during RUN SHALL NOT affect the result.
REQ-028 WIDTH=1, sgn=1: bit 0 is the sign bit, so 1 (-1) < 0.

Reset
REQ-029 rst=1 at a rising edge SHALL force: state IDLE, busy=0, done=0, lt=0, eq=0, gt=0, y=0, counter=0.
REQ-030 rst SHALL override start at the same edge.
REQ-031 rst during RUN SHALL abort the comparison with no done pulse, and results SHALL return to their reset values.
REQ-032 The first start after rst deasserts SHALL behave per REQ-015..REQ-023.

Verification
REQ-033 WIDTH=8, sgn=0, a=0x80, b=0x7F, start at E0 -> busy for 8 cycles; after E8: done=1, gt=1, lt=0, eq=0, y=0.
REQ-034 WIDTH=8, sgn=1, a=0x80, b=0x7F -> lt=1, y=1. Also sgn=1, a=0xFE, b=0xFF -> lt=1.
REQ-035 WIDTH=8, a=b=0xA5, either sgn -> eq=1, y=1, lt=gt=0.
REQ-036 Start held high for 20 cycles, a=3, b=5 unsigned -> comparisons at E0, E9 and E18:
- done pulses after E8 and E17, never two consecutive cycles;
- lt=1 held between pulses;
- operand changes mid-RUN ignored.
REQ-037 rst=1 at E4 of a WIDTH=8 run (after prior result gt=1) -> busy=0, lt=eq=gt=y=0, no done pulse; new start a=1, b=1 -> eq=1 after 8 cycles.
REQ-038 WIDTH=1: sgn=0, a=0, b=1 -> lt=1, done one cycle after start. sgn=1, same operands -> gt=1.
